sha512_padder: RTL and testbench
================================

Name: sha512_padder

Overview:
- Producer side of the SHA-512 chunk interface.
- Accepts a message as a byte stream, appends FIPS 180-4 padding (0x80, zeros, 128-bit big-endian bit length) and emits 1024-bit chunks over a valid/ready handshake to the chunk compressor.
- Flags the first and last chunk of each message so the top level knows when to load the IV and when the digest is final.

Parameters:
- LEN_W, 64, width of the internal byte counter. Bit length is {byte_cnt, 3'b000}, zero-extended to 128 bits.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  padder accepts a beat this cycle
- in_byte  in  8  message byte
- in_last  in  1  beat is the final beat of the message
- in_null  in  1  beat carries no byte. Only legal with in_last=1; used for zero-length messages.
- chunk  out  1024  byte 0 at [1023:1016], byte 127 at [7:0], i.e. big-endian words, word j at [64*(15-j)+:64]
- chunk_valid  out  1  chunk is stable and offered
- chunk_ready  in  1  consumer takes chunk
- chunk_first  out  1  chunk is the first chunk of its message
- chunk_last  out  1  chunk is the final, padded chunk of its message

Behaviour:
- Reset values: in_ready=0, chunk_valid=0, chunk_first=0, chunk_last=0, chunk=0, byte index idx=0, byte_cnt=0, first_flag=1.
- States: FILL, PAD, LENBLK, EMIT.
- FILL:
  - in_ready=1.
  - On in_valid & !in_null: write in_byte to byte idx, idx++, byte_cnt++.
  - If the accepted byte lands at idx=127 → EMIT with pad_pending=in_last.
  - Else if in_last → PAD.
  - A null beat with in_last → PAD at the current idx.
- PAD (one cycle, in_ready=0):
  - Byte idx := 0x80; bytes idx+1..127 := 0.
  - If idx<=111: bytes 112..127 := 128-bit bit length; final=1.
  - Else: final=0, len_pending=1.
  - → EMIT.
- LENBLK (one cycle): bytes 0..111 := 0; bytes 112..127 := length; final=1 → EMIT.
- EMIT:
  - chunk_valid=1; chunk, chunk_first and chunk_last held stable until chunk_ready.
  - On handshake, first_flag := final, then:
    - if final: clear idx and byte_cnt → FILL;
    - else if pad_pending: idx=0 → PAD;
    - else if len_pending → LENBLK;
    - else idx=0 → FILL.
- Output flags: chunk_last=final. chunk_first=first_flag captured at EMIT entry.
- Latency: chunk_valid rises 1 cycle after the 128th byte is accepted, or 2 cycles after the last byte when padding is needed.
- in_ready is 0 in PAD, LENBLK and EMIT. No bytes are accepted while a chunk is offered.
- in_null without in_last: ignored, beat consumed.
- byte_cnt wraps modulo 2^LEN_W without error.
- Reset asserted mid-message or mid-EMIT: immediate return to reset values; the partial message is discarded.
- chunk_ready while chunk_valid=0: ignored.

Optional Feature:
- Macro SHA512_PADDER_CHUNK_CNT_EN.
- Defined: adds output chunk_idx [15:0], the 0-based index of the offered chunk within its message. It is valid with chunk_valid, increments on each handshake, clears after the handshake of a chunk_last chunk, resets to 0, and saturates at 16'hFFFF.
- Undefined: no port, no counter logic.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63), chunk_ready=1 → one chunk with word0=0x6162638000000000, words1..14=0, word15=0x18, first=last=1.
- Zero-length message (single in_null+in_last beat) → one chunk with word0=0x8000000000000000, rest 0, first=last=1.
- 112 bytes of 0x00 → chunk 1: bytes 0..111=0, byte112=0x80, rest 0, first=1, last=0. Chunk 2: zeros, word15=0x380, first=0, last=1.
- 128 bytes of 0xFF → chunk 1 all ones, last=0. Chunk 2: word0=0x8000000000000000, word15=0x400, last=1. No extra chunk.
- Backpressure: chunk_ready held 0 for 10 cycles after chunk_valid on "abc" → chunk and flags unchanged, in_ready=0 throughout. Handshake on cycle 11, then in_ready=1 the next cycle.
- Reset pulse after 50 bytes, then "abc" → output identical to the first scenario, first=1.

Source files
------------

// File: rtl/sha512_padder.sv
// sha512_padder: byte-stream to padded 1024-bit SHA-512 chunk producer.
// Appends 0x80, zero fill and the 128-bit big-endian message bit length.
// Flags the first and the last chunk of each message.
// Optional build macro: SHA512_PADDER_CHUNK_CNT_EN adds the chunk_idx output.
//
// state  | meaning
// FILL   | accepting message bytes into the chunk buffer
// PAD    | one cycle: write 0x80, zero fill, length if it fits
// LENBLK | one cycle: build an extra chunk holding only the length
// EMIT   | chunk offered downstream, held until chunk_ready
module sha512_padder #(
  parameter int LEN_W = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_byte,
  input  logic          in_last,
  input  logic          in_null,
  output logic [1023:0] chunk,
  output logic          chunk_valid,
  input  logic          chunk_ready,
  output logic          chunk_first,
`ifdef SHA512_PADDER_CHUNK_CNT_EN
  output logic          chunk_last,
  output logic [15:0]   chunk_idx
`else
  output logic          chunk_last
`endif
);

  typedef enum logic [1:0] {FILL, PAD, LENBLK, EMIT} state_t;

  state_t             state;
  logic [6:0]         idx;
  logic [LEN_W-1:0]   byte_cnt;
  logic               first_flag;
  logic               pad_pending;
  logic               len_pending;
  logic [127:0]       bit_len;

  assign bit_len = {{(125-LEN_W){1'b0}}, byte_cnt, 3'b000};

  // Main FSM; chunk doubles as the byte buffer, so it is stable while offered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FILL;
      in_ready    <= 1'b0;
      chunk       <= '0;
      chunk_valid <= 1'b0;
      chunk_first <= 1'b0;
      chunk_last  <= 1'b0;
      idx         <= '0;
      byte_cnt    <= '0;
      first_flag  <= 1'b1;
      pad_pending <= 1'b0;
      len_pending <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            if (!in_null) begin
              chunk[{~idx, 3'b000} +: 8] <= in_byte;
              idx      <= idx + 7'd1;
              byte_cnt <= byte_cnt + 1'b1;
              if (idx == 7'd127) begin
                state       <= EMIT;
                in_ready    <= 1'b0;
                pad_pending <= in_last;
                chunk_valid <= 1'b1;
                chunk_first <= first_flag;
                chunk_last  <= 1'b0;
              end else if (in_last) begin
                state    <= PAD;
                in_ready <= 1'b0;
              end
            end else if (in_last) begin
              state    <= PAD;
              in_ready <= 1'b0;
            end
          end
        end
        PAD: begin
          for (int i = 0; i < 128; i++) begin
            if (7'(i) == idx) chunk[8*(127-i) +: 8] <= 8'h80;
            else if (7'(i) > idx) chunk[8*(127-i) +: 8] <= 8'h00;
          end
          pad_pending <= 1'b0;
          if (idx <= 7'd111) begin
            chunk[127:0] <= bit_len;
            chunk_last   <= 1'b1;
          end else begin
            chunk_last  <= 1'b0;
            len_pending <= 1'b1;
          end
          chunk_valid <= 1'b1;
          chunk_first <= first_flag;
          state       <= EMIT;
        end
        LENBLK: begin
          chunk       <= {896'b0, bit_len};
          len_pending <= 1'b0;
          chunk_last  <= 1'b1;
          chunk_valid <= 1'b1;
          chunk_first <= first_flag;
          state       <= EMIT;
        end
        EMIT: begin
          if (chunk_ready) begin
            chunk_valid <= 1'b0;
            first_flag  <= chunk_last;
            if (chunk_last) begin
              idx      <= '0;
              byte_cnt <= '0;
              in_ready <= 1'b1;
              state    <= FILL;
            end else if (pad_pending) begin
              idx   <= '0;
              state <= PAD;
            end else if (len_pending) begin
              state <= LENBLK;
            end else begin
              idx      <= '0;
              in_ready <= 1'b1;
              state    <= FILL;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef SHA512_PADDER_CHUNK_CNT_EN
  // Per-message chunk index, saturating, cleared after the final chunk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chunk_idx <= '0;
    end else if (chunk_valid && chunk_ready) begin
      if (chunk_last) chunk_idx <= '0;
      else if (chunk_idx != 16'hFFFF) chunk_idx <= chunk_idx + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha512_padder.sv
// tb_sha512_padder: directed vectors for sha512_padder with hand-computed chunks.
module tb_sha512_padder;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_byte = 8'h00;
  logic          in_last = 1'b0;
  logic          in_null = 1'b0;
  logic [1023:0] chunk;
  logic          chunk_valid;
  logic          chunk_ready = 1'b1;
  logic          chunk_first;
  logic          chunk_last;
`ifdef SHA512_PADDER_CHUNK_CNT_EN
  logic [15:0]   chunk_idx;
`endif

  int checks = 0;
  int failures = 0;

  logic [1023:0] q_data[$];
  logic          q_first[$];
  logic          q_last[$];

  localparam logic [1023:0] EXP_ABC  = {64'h6162638000000000, 896'h0, 64'h18};
  localparam logic [1023:0] EXP_NULL = {64'h8000000000000000, 960'h0};
  localparam logic [1023:0] EXP_Z1   = {896'h0, 64'h8000000000000000, 64'h0};
  localparam logic [1023:0] EXP_Z2   = {960'h0, 64'h380};
  localparam logic [1023:0] EXP_F1   = {1024{1'b1}};
  localparam logic [1023:0] EXP_F2   = {64'h8000000000000000, 896'h0, 64'h400};

  sha512_padder #(.LEN_W(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_byte     (in_byte),
    .in_last     (in_last),
    .in_null     (in_null),
    .chunk       (chunk),
    .chunk_valid (chunk_valid),
    .chunk_ready (chunk_ready),
    .chunk_first (chunk_first),
`ifdef SHA512_PADDER_CHUNK_CNT_EN
    .chunk_last  (chunk_last),
    .chunk_idx   (chunk_idx)
`else
    .chunk_last  (chunk_last)
`endif
  );

  always #5 clk = ~clk;

  // Record every chunk whose handshake completes at the following edge.
  always @(negedge clk) begin
    if (!reset && chunk_valid && chunk_ready) begin
      q_data.push_back(chunk);
      q_first.push_back(chunk_first);
      q_last.push_back(chunk_last);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_chunk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    for (int j = 0; j < 16; j++)
      chk($sformatf("%s_w%0d", tag, j), got[64*(15-j) +: 64], exp[64*(15-j) +: 64]);
  endtask

  task automatic send(input logic [7:0] b, input logic last, input logic nul);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    in_null  = nul;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_null  = 1'b0;
  endtask

  task automatic send_abc();
    send(8'h61, 1'b0, 1'b0);
    send(8'h62, 1'b0, 1'b0);
    send(8'h63, 1'b1, 1'b0);
  endtask

  task automatic expect_chunk(input string tag, input logic [1023:0] exp, input logic ef, input logic el);
    int t = 0;
    logic [1023:0] d;
    logic f, l;
    while (q_data.size() == 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (q_data.size() == 0) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      d = q_data.pop_front();
      f = q_first.pop_front();
      l = q_last.pop_front();
      chk_chunk(tag, d, exp);
      chk({tag, "_first"}, 64'(f), 64'(ef));
      chk({tag, "_last"}, 64'(l), 64'(el));
    end
  endtask

  initial begin
    int t;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_valid", 64'(chunk_valid), 64'd0);
    chk("rst_first", 64'(chunk_first), 64'd0);
    chk("rst_last", 64'(chunk_last), 64'd0);
    chk("rst_w0", chunk[1023:960], 64'd0);
    chk("rst_w15", chunk[63:0], 64'd0);
    reset = 1'b0;

    // "abc" with latency: PAD cycle, then chunk offered
    send_abc();
    @(negedge clk);
    chk("lat_pad", 64'(chunk_valid), 64'd0);
    @(negedge clk);
    chk("lat_emit", 64'(chunk_valid), 64'd1);
    expect_chunk("abc", EXP_ABC, 1'b1, 1'b1);

    // zero-length message
    send(8'h00, 1'b1, 1'b1);
    expect_chunk("null", EXP_NULL, 1'b1, 1'b1);

    // null beat without last is dropped
    send(8'h61, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b1);
    send(8'h62, 1'b0, 1'b0);
    send(8'h63, 1'b1, 1'b0);
    expect_chunk("abnc", EXP_ABC, 1'b1, 1'b1);

    // 112 zero bytes: length spills into a second chunk
    for (int i = 0; i < 112; i++) send(8'h00, (i == 111), 1'b0);
    expect_chunk("z112_c1", EXP_Z1, 1'b1, 1'b0);
    expect_chunk("z112_c2", EXP_Z2, 1'b0, 1'b1);

    // 128 0xFF bytes: full chunk then pad chunk, nothing more
    for (int i = 0; i < 128; i++) send(8'hFF, (i == 127), 1'b0);
    expect_chunk("ff128_c1", EXP_F1, 1'b1, 1'b0);
    expect_chunk("ff128_c2", EXP_F2, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    chk("ff128_no_extra", 64'(q_data.size()), 64'd0);

    // backpressure on "abc"
    chunk_ready = 1'b0;
    send_abc();
    t = 0;
    while (!chunk_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid_seen", 64'(chunk_valid), 64'd1);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      chk_chunk($sformatf("bp_hold%0d", c), chunk, EXP_ABC);
      chk($sformatf("bp_valid%0d", c), 64'(chunk_valid), 64'd1);
      chk($sformatf("bp_in_ready%0d", c), 64'(in_ready), 64'd0);
      chk($sformatf("bp_first%0d", c), 64'(chunk_first), 64'd1);
      chk($sformatf("bp_last%0d", c), 64'(chunk_last), 64'd1);
    end
    @(posedge clk);
    #1 chunk_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("bp_valid_after", 64'(chunk_valid), 64'd0);
    chk("bp_in_ready_after", 64'(in_ready), 64'd1);
    expect_chunk("bp", EXP_ABC, 1'b1, 1'b1);

    // reset in the middle of a message, then "abc"
    for (int i = 0; i < 50; i++) send(8'(i + 1), 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_valid", 64'(chunk_valid), 64'd0);
    chk("mid_rst_w0", chunk[1023:960], 64'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_queue", 64'(q_data.size()), 64'd0);
    send_abc();
    expect_chunk("rst_abc", EXP_ABC, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
